// File: rtl/usb3_ep_pkg.sv
`default_nettype none
// ============================================================================
// usb3_ep_pkg : shared constants, FSM encodings and helpers for the
//               USB3 endpoint ping-pong buffer.
// Rev 1.0
// ============================================================================
package usb3_ep_pkg;

  localparam int unsigned ACK_CYC_DEFAULT = 4;
  localparam int unsigned ACK_CNT_W       = 4;

  localparam logic [1:0] c_IN_IDLE   = 2'd0;
  localparam logic [1:0] c_IN_COMMIT = 2'd1;
  localparam logic [1:0] c_IN_SWAP   = 2'd2;

  localparam logic [1:0] c_OUT_IDLE  = 2'd0;
  localparam logic [1:0] c_OUT_ARM   = 2'd1;
  localparam logic [1:0] c_OUT_SWAP  = 2'd2;

  function automatic logic rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb3_ep_pingpong_if.sv
`default_nettype none
// ============================================================================
// usb3_ep_pingpong_if : writer/reader buffer bus of the endpoint ping-pong.
// Rev 1.0
// ============================================================================
interface usb3_ep_pingpong_if #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = ADDR_W + 3
);
  logic [ADDR_W-1:0] buf_in_addr;
  logic [31:0]       buf_in_data;
  logic              buf_in_wren;
  logic              buf_in_ready;
  logic              buf_in_commit;
  logic [LEN_W-1:0]  buf_in_commit_len;
  logic              buf_in_commit_ack;
  logic [ADDR_W-1:0] buf_out_addr;
  logic [31:0]       buf_out_q;
  logic [LEN_W-1:0]  buf_out_len;
  logic              buf_out_hasdata;
  logic              buf_out_arm;
  logic              buf_out_arm_ack;
  logic              err_overflow;
  logic              err_underflow;

  modport slave (
    input  buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
    input  buf_out_addr, buf_out_arm,
    output buf_in_ready, buf_in_commit_ack, buf_out_q, buf_out_len, buf_out_hasdata,
    output buf_out_arm_ack, err_overflow, err_underflow
  );

  modport master (
    output buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
    output buf_out_addr, buf_out_arm,
    input  buf_in_ready, buf_in_commit_ack, buf_out_q, buf_out_len, buf_out_hasdata,
    input  buf_out_arm_ack, err_overflow, err_underflow
  );
endinterface
`default_nettype wire

// File: rtl/usb3_ep_dpram.sv
`default_nettype none
// ============================================================================
// usb3_ep_dpram : simple dual-port RAM, one write port, one registered read.
// Rev 1.0
// ============================================================================
module usb3_ep_dpram #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule
`default_nettype wire

// File: rtl/usb3_ep_pingpong.sv
`default_nettype none
// ============================================================================
// usb3_ep_pingpong : two-buffer endpoint store; writer commits a filled
//                    buffer, reader arms to release the drained one.
// Rev 1.0
// ============================================================================
module usb3_ep_pingpong
  import usb3_ep_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LEN_W   = ADDR_W + 3,
  parameter int ACK_CYC = ACK_CYC_DEFAULT
) (
  input  logic              local_clk,
  input  logic              reset_n,
  usb3_ep_pingpong_if.slave bus
);
  localparam logic [LEN_W-1:0]     c_MAX_LEN  = LEN_W'(32'd4 << ADDR_W);
  localparam logic [ACK_CNT_W-1:0] c_ACK_LAST = ACK_CNT_W'(ACK_CYC - 1);

  logic [1:0]           in_st_q, in_st_d, out_st_q, out_st_d;
  logic [ACK_CNT_W-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic                 commit_q, arm_q, ptr_in_q, ptr_out_q, ovf_q, unf_q;
  logic [1:0]           cnt_q;
  logic [LEN_W-1:0]     len_q [2];

  logic w_commit_rise, w_arm_rise, w_commit_take, w_arm_take, w_len_over;
  logic w_in_swap, w_out_swap, w_ready, w_in_ack, w_out_ack, w_hasdata;
  logic [LEN_W-1:0] w_len_clamped, w_out_len;
  logic [31:0]      w_rdata;

  assign w_commit_rise = rise(bus.buf_in_commit, commit_q);
  assign w_arm_rise    = rise(bus.buf_out_arm, arm_q);
  assign w_commit_take = w_commit_rise && (in_st_q == c_IN_IDLE) && (cnt_q != 2'd2);
  assign w_arm_take    = w_arm_rise && (out_st_q == c_OUT_IDLE) && (cnt_q != 2'd0);
  assign w_in_swap     = (in_st_q == c_IN_SWAP);
  assign w_out_swap    = (out_st_q == c_OUT_SWAP);
  assign w_len_over    = (bus.buf_in_commit_len > c_MAX_LEN);
  assign w_len_clamped = w_len_over ? c_MAX_LEN : bus.buf_in_commit_len;

  // State register: both FSMs and their independent ack counters
  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      in_st_q   <= c_IN_IDLE;
      out_st_q  <= c_OUT_IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      in_st_q   <= in_st_d;
      out_st_q  <= out_st_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  always_comb begin
    in_st_d  = in_st_q;
    in_cnt_d = in_cnt_q;
    case (in_st_q)
      c_IN_IDLE: if (w_commit_take) begin
        in_st_d  = c_IN_COMMIT;
        in_cnt_d = '0;
      end
      c_IN_COMMIT: if (in_cnt_q == c_ACK_LAST) in_st_d = c_IN_SWAP;
                   else in_cnt_d = in_cnt_q + 1'b1;
      default: in_st_d = c_IN_IDLE;
    endcase
  end

  always_comb begin
    out_st_d  = out_st_q;
    out_cnt_d = out_cnt_q;
    case (out_st_q)
      c_OUT_IDLE: if (w_arm_take) begin
        out_st_d  = c_OUT_ARM;
        out_cnt_d = '0;
      end
      c_OUT_ARM: if (out_cnt_q == c_ACK_LAST) out_st_d = c_OUT_SWAP;
                 else out_cnt_d = out_cnt_q + 1'b1;
      default: out_st_d = c_OUT_IDLE;
    endcase
  end

  always_comb begin
    w_in_ack  = (in_st_q == c_IN_COMMIT);
    w_out_ack = (out_st_q == c_OUT_ARM);
    w_ready   = (cnt_q != 2'd2) && (in_st_q == c_IN_IDLE);
    w_hasdata = (cnt_q != 2'd0);
    w_out_len = len_q[ptr_out_q];
  end

  // Coincident swaps hand one buffer in and one out, so the count holds
  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      commit_q  <= 1'b0;
      arm_q     <= 1'b0;
      ptr_in_q  <= 1'b0;
      ptr_out_q <= 1'b0;
      cnt_q     <= 2'd0;
      len_q[0]  <= '0;
      len_q[1]  <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      commit_q <= bus.buf_in_commit;
      arm_q    <= bus.buf_out_arm;
      ovf_q    <= (w_commit_rise && !w_commit_take) || (w_commit_take && w_len_over);
      unf_q    <= w_arm_rise && !w_arm_take;
      if (w_commit_take) len_q[ptr_in_q] <= w_len_clamped;
      if (w_in_swap)     ptr_in_q  <= ~ptr_in_q;
      if (w_out_swap)    ptr_out_q <= ~ptr_out_q;
      if (w_in_swap && !w_out_swap)      cnt_q <= cnt_q + 2'd1;
      else if (w_out_swap && !w_in_swap) cnt_q <= cnt_q - 2'd1;
    end
  end

  usb3_ep_dpram #(
    .AW (ADDR_W + 1),
    .DW (32)
  ) u_ram (
    .clk_i   (local_clk),
    .we_i    (bus.buf_in_wren & w_ready),
    .waddr_i ({ptr_in_q, bus.buf_in_addr}),
    .wdata_i (bus.buf_in_data),
    .raddr_i ({ptr_out_q, bus.buf_out_addr}),
    .rdata_o (w_rdata)
  );

  assign bus.buf_in_ready      = w_ready;
  assign bus.buf_in_commit_ack = w_in_ack;
  assign bus.buf_out_q         = w_rdata;
  assign bus.buf_out_len       = w_out_len;
  assign bus.buf_out_hasdata   = w_hasdata;
  assign bus.buf_out_arm_ack   = w_out_ack;
  assign bus.err_overflow      = ovf_q;
  assign bus.err_underflow     = unf_q;
endmodule
`default_nettype wire

// File: tb/tb_usb3_ep_pingpong.sv
`default_nettype none
// ============================================================================
// tb_usb3_ep_pingpong : randomized bench with a packet-queue reference model.
// Rev 1.0
// ============================================================================
module tb_usb3_ep_pingpong;
  localparam int ADDR_W  = 8;
  localparam int LEN_W   = ADDR_W + 3;
  localparam int ACK_CYC = 4;
  localparam int WIN     = ACK_CYC + 3;
  localparam int MAX_LEN = 4 << ADDR_W;

  typedef struct {
    int               len;
    int               nw;
    logic [7:0][31:0] w;
  } pkt_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  pkt_t q_m[$];
  bit   s_in_ack [WIN];
  bit   s_out_ack[WIN];
  bit   s_hd     [WIN];

  usb3_ep_pingpong_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  usb3_ep_pingpong #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ACK_CYC(ACK_CYC)) dut (
    .local_clk (clk),
    .reset_n   (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pkt(output pkt_t p);
    p.nw = $urandom_range(1, 8);
    for (int i = 0; i < 8; i++) p.w[i] = $urandom;
    if ($urandom_range(0, 4) == 0) p.len = $urandom_range(MAX_LEN + 1, 2047);
    else                           p.len = $urandom_range(1, MAX_LEN);
  endtask

  task automatic load_pkt(input pkt_t p);
    for (int i = 0; i < p.nw; i++) begin
      bus.buf_in_addr = ADDR_W'(i);
      bus.buf_in_data = p.w[i];
      bus.buf_in_wren = 1'b1;
      tick();
    end
    bus.buf_in_wren = 1'b0;
  endtask

  // Raise commit and/or arm, watch the handshake window, then score against the queue
  task automatic apply(input bit c, input bit a, input pkt_t p);
    int   n_ia, n_oa, n_ov, n_un, exp_len;
    bit   c_ok, a_ok;
    pkt_t h;
    c_ok    = c && (q_m.size() < 2);
    a_ok    = a && (q_m.size() > 0);
    exp_len = (p.len > MAX_LEN) ? MAX_LEN : p.len;
    bus.buf_in_commit_len = LEN_W'(p.len);
    bus.buf_in_commit     = c;
    bus.buf_out_arm       = a;
    tick();
    bus.buf_in_commit = 1'b0;
    bus.buf_out_arm   = 1'b0;
    n_ia = 0; n_oa = 0; n_ov = 0; n_un = 0;
    for (int k = 0; k < WIN; k++) begin
      s_in_ack[k]  = bus.buf_in_commit_ack;
      s_out_ack[k] = bus.buf_out_arm_ack;
      s_hd[k]      = bus.buf_out_hasdata;
      n_ia += int'(bus.buf_in_commit_ack);
      n_oa += int'(bus.buf_out_arm_ack);
      n_ov += int'(bus.err_overflow);
      n_un += int'(bus.err_underflow);
      tick();
    end
    check("commit_ack_cycles", n_ia, c_ok ? ACK_CYC : 0);
    check("arm_ack_cycles", n_oa, a_ok ? ACK_CYC : 0);
    check("err_overflow_pulses", n_ov, (c && (!c_ok || p.len > MAX_LEN)) ? 1 : 0);
    check("err_underflow_pulses", n_un, (a && !a_ok) ? 1 : 0);
    if (a_ok) void'(q_m.pop_front());
    if (c_ok) begin
      h     = p;
      h.len = exp_len;
      q_m.push_back(h);
    end
    check("buf_in_ready", bus.buf_in_ready, q_m.size() < 2);
    check("buf_out_hasdata", bus.buf_out_hasdata, q_m.size() > 0);
    if (q_m.size() > 0) begin
      h = q_m[0];
      check("buf_out_len", bus.buf_out_len, h.len);
      for (int i = 0; i < h.nw; i++) begin
        bus.buf_out_addr = ADDR_W'(i);
        tick();
        check("buf_out_q", bus.buf_out_q, h.w[i]);
      end
    end
  endtask

  initial begin
    pkt_t p, pa, pb, pc;
    int   r;
    bus.buf_in_addr = '0;
    bus.buf_in_data = '0;
    bus.buf_in_wren = 1'b0;
    bus.buf_in_commit = 1'b0;
    bus.buf_in_commit_len = '0;
    bus.buf_out_addr = '0;
    bus.buf_out_arm = 1'b0;
    p = '{len: 0, nw: 0, w: '0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", bus.buf_in_ready, 1);
    check("rst_hasdata", bus.buf_out_hasdata, 0);
    check("rst_len", bus.buf_out_len, 0);
    check("rst_acks", {bus.buf_in_commit_ack, bus.buf_out_arm_ack}, 0);
    check("rst_errs", {bus.err_overflow, bus.err_underflow}, 0);
    rst_n = 1'b1;
    tick();

    // Basic commit: 0xA0..0xA3, length 16, ack/hasdata timing
    p.nw = 4; p.len = 16;
    for (int i = 0; i < 8; i++) p.w[i] = 32'hA0 + 32'(i);
    load_pkt(p);
    apply(1'b1, 1'b0, p);
    check("lat_ack_first", s_in_ack[0], 1);
    check("lat_ack_last", s_in_ack[ACK_CYC-1], 1);
    check("lat_ack_end", s_in_ack[ACK_CYC], 0);
    check("lat_hd_before", s_hd[ACK_CYC], 0);
    check("lat_hd_edge5", s_hd[ACK_CYC+1], 1);
    apply(1'b0, 1'b1, p);

    // Arm with nothing pending
    apply(1'b0, 1'b1, p);

    // Fill both buffers, reject a third commit, discard writes while full
    rand_pkt(pa); pa.len = 8;  pa.nw = 2; load_pkt(pa); apply(1'b1, 1'b0, pa);
    rand_pkt(pb); pb.len = 12; pb.nw = 3; load_pkt(pb); apply(1'b1, 1'b0, pb);
    check("full_ready", bus.buf_in_ready, 0);
    bus.buf_in_addr = '0; bus.buf_in_data = 32'hDEADBEEF; bus.buf_in_wren = 1'b1;
    tick();
    bus.buf_in_wren = 1'b0;
    rand_pkt(p); p.len = 20;
    apply(1'b1, 1'b0, p);
    check("full_len_8", bus.buf_out_len, 8);
    apply(1'b0, 1'b1, p);
    check("armed_len_12", bus.buf_out_len, 12);
    // The freed buffer is A's, so unwritten word 0 keeps A's data
    pc.nw = 1; pc.len = 4; pc.w = '0; pc.w[0] = pa.w[0];
    apply(1'b1, 1'b0, pc);
    apply(1'b0, 1'b1, p);
    apply(1'b0, 1'b1, p);

    // Coincident commit and arm with one buffer pending
    rand_pkt(p); p.len = 40; load_pkt(p); apply(1'b1, 1'b0, p);
    rand_pkt(p); p.len = 44; load_pkt(p); apply(1'b1, 1'b1, p);
    check("both_ack_in", s_in_ack[0], 1);
    check("both_ack_out", s_out_ack[0], 1);
    apply(1'b0, 1'b1, p);

    // Oversize length clamps
    rand_pkt(p); p.len = 2047; load_pkt(p); apply(1'b1, 1'b0, p);
    check("clamp_len", bus.buf_out_len, MAX_LEN);
    apply(1'b0, 1'b1, p);

    // Reset during the second ack cycle
    rand_pkt(p); p.len = 16; load_pkt(p);
    bus.buf_in_commit_len = LEN_W'(16);
    bus.buf_in_commit = 1'b1;
    tick();
    bus.buf_in_commit = 1'b0;
    check("midrst_ack_c1", bus.buf_in_commit_ack, 1);
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_ack", bus.buf_in_commit_ack, 0);
    check("midrst_ready", bus.buf_in_ready, 1);
    check("midrst_hasdata", bus.buf_out_hasdata, 0);
    check("midrst_len", bus.buf_out_len, 0);
    tick();
    rst_n = 1'b1;
    q_m.delete();
    tick();
    rand_pkt(p); load_pkt(p); apply(1'b1, 1'b0, p);

    // Randomized traffic against the queue model
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 3);
      rand_pkt(p);
      if (r != 2) load_pkt(p);
      case (r)
        0, 1:    apply(1'b1, 1'b0, p);
        2:       apply(1'b0, 1'b1, p);
        default: apply(1'b1, 1'b1, p);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
